// File: rtl/qdot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qdot_pkg
// Description : Shared types and helpers for the multi-lane Q-format
//               dot-product engine: FSM state encoding, width calculators
//               for the product / lane-sum / accumulator datapath, and the
//               saturating reduction used when QDOT_SAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package qdot_pkg;

  // Engine control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Working width of the generic clamp helper; must cover the widest
  // accumulator any instance can build.
  localparam int C_ACC_MAX_W = 256;

  // Lane product after dropping Q fractional bits.
  function automatic int prod_w(input int n, input int q);
    return 2 * n - q;
  endfunction

  // Sum of all lane products in one beat, with growth headroom.
  function automatic int lsum_w(input int n, input int q, input int lanes);
    return prod_w(n, q) + $clog2(lanes);
  endfunction

  // Job accumulator, wide enough for 2^len_w-1 worst-case beats.
  function automatic int acc_w(input int n, input int q, input int lanes,
                               input int len_w);
    return lsum_w(n, q, lanes) + len_w;
  endfunction

  // Clamp a sign-extended accumulator into the signed n-bit range.
  function automatic logic signed [C_ACC_MAX_W-1:0] sat_to_n(
      input logic signed [C_ACC_MAX_W-1:0] acc, input int n);
    logic signed [C_ACC_MAX_W-1:0] hi;
    logic signed [C_ACC_MAX_W-1:0] lo;
    for (int i = 0; i < C_ACC_MAX_W; i++) begin
      hi[i] = (i < n - 1);
    end
    // -2^(n-1) is the bitwise complement of 2^(n-1)-1.
    lo = ~hi;
    if (acc > hi) begin
      return hi;
    end else if (acc < lo) begin
      return lo;
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qdot_lane_mul.sv
`default_nettype none
// ============================================================================
// Module      : qdot_lane_mul
// Description : One multiply lane. Signed N x N multiply, then an arithmetic
//               shift right by Q (truncation toward -inf). Purely
//               combinational.
// Ports       : a, b - N-bit signed Q-format operands
//               p    - (2N-Q)-bit signed product
// Revision    : 1.0 - initial release
// ============================================================================
module qdot_lane_mul
  import qdot_pkg::*;
#(
  parameter int N = 32,
  parameter int Q = 15,
  localparam int C_PROD_W = prod_w(N, Q)
) (
  input  logic [N-1:0]        a,
  input  logic [N-1:0]        b,
  output logic [C_PROD_W-1:0] p
);

  logic signed [2*N-1:0] w_a_ext;
  logic signed [2*N-1:0] w_b_ext;
  logic signed [2*N-1:0] w_full;

  // Sign-extend to the full product width so the multiply is exact.
  assign w_a_ext = {{N{a[N-1]}}, a};
  assign w_b_ext = {{N{b[N-1]}}, b};
  assign w_full  = w_a_ext * w_b_ext;

  // Dropping the low Q bits of a two's-complement value is >>> Q.
  assign p = w_full[2*N-1:Q];

  generate
    if (Q > 0) begin : g_frac
      logic w_unused_frac;
      assign w_unused_frac = ^w_full[Q-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/qdot_engine.sv
`default_nettype none
// ============================================================================
// Module      : qdot_engine
// Description : Streaming multi-lane fixed-point dot-product engine.
//               Accepts LANES operand pairs per beat for a job of `len`
//               beats, sums lane products into a stage-1 register, adds
//               stage 1 into a full-precision accumulator, and returns the
//               N-bit result over a valid/ready handshake.
// Config      : QDOT_SAT_EN - when defined, out_c saturates on overflow;
//               otherwise out_c is the two's-complement wrap of the
//               accumulator. ovfl is identical in both builds.
// Ports       : clk, rst_n          - clock, async active-low reset
//               start, len, clear   - job control (clear aborts)
//               in_valid/in_ready   - operand beat handshake, in_a/in_b
//               out_valid/out_ready - result handshake, out_c/ovfl
//               busy                - engine not idle
// Revision    : 1.0 - initial release
// ============================================================================
module qdot_engine
  import qdot_pkg::*;
#(
  parameter int N     = 32,
  parameter int Q     = 15,
  parameter int LANES = 4,
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*N-1:0] in_a,
  input  logic [LANES*N-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_c,
  output logic               ovfl,
  output logic               busy
);

  localparam int C_PROD_W = prod_w(N, Q);
  localparam int C_LSUM_W = lsum_w(N, Q, LANES);
  localparam int C_ACC_W  = acc_w(N, Q, LANES, LEN_W);

  state_t                     r_state;
  state_t                     w_next;
  logic [LEN_W-1:0]           r_len;
  logic [LEN_W-1:0]           r_count;
  logic signed [C_LSUM_W-1:0] r_s1;
  logic                       r_s1_valid;
  logic signed [C_ACC_W-1:0]  r_acc;

  logic [C_PROD_W-1:0]        w_prod [LANES];
  logic signed [C_LSUM_W-1:0] w_lane_sum;
  logic                       w_accept;
  logic                       w_last_beat;
  logic                       w_start_acc;
  logic [C_ACC_W-N:0]         w_hi_bits;

  // --------------------------------------------------------------------------
  // Lane multipliers and beat sum
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      qdot_lane_mul #(
        .N (N),
        .Q (Q)
      ) u_mul (
        .a (in_a[k*N +: N]),
        .b (in_b[k*N +: N]),
        .p (w_prod[k])
      );
    end
  endgenerate

  always_comb begin
    w_lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      w_lane_sum = w_lane_sum + C_LSUM_W'($signed(w_prod[k]));
    end
  end

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------
  assign w_accept    = in_valid && in_ready;
  assign w_last_beat = w_accept && ((r_count + LEN_W'(1)) == r_len);
  assign w_start_acc = (r_state == IDLE) && start && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = (r_count < r_len);
        if (w_last_beat) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    // Abort wins over every other transition.
    if (clear) begin
      w_next = IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: beat counter, stage 1, accumulator
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_count    <= '0;
      r_s1       <= '0;
      r_s1_valid <= 1'b0;
      r_acc      <= '0;
    end else if (clear) begin
      r_count    <= '0;
      r_s1_valid <= 1'b0;
      r_acc      <= '0;
    end else if (w_start_acc) begin
      r_len      <= len;
      r_count    <= '0;
      r_s1_valid <= 1'b0;
      r_acc      <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1    <= w_lane_sum;
        r_count <= r_count + LEN_W'(1);
      end
      if (r_s1_valid) begin
        r_acc <= r_acc + C_ACC_W'(r_s1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Result reduction
  // --------------------------------------------------------------------------
  // The accumulator fits in N signed bits iff every bit from N-1 upward
  // equals the sign bit.
  assign w_hi_bits = r_acc[C_ACC_W-1:N-1];
  assign ovfl      = !((&w_hi_bits) || !(|w_hi_bits));

`ifdef QDOT_SAT_EN
  logic signed [C_ACC_MAX_W-1:0] w_sat;
  logic                          w_unused_sat;
  assign w_sat        = sat_to_n(C_ACC_MAX_W'(r_acc), N);
  assign out_c        = w_sat[N-1:0];
  assign w_unused_sat = ^w_sat[C_ACC_MAX_W-1:N];
`else
  assign out_c = r_acc[N-1:0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_qdot_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_qdot_engine
// Description : Self-checking bench for qdot_engine. Directed scenarios plus
//               randomized jobs, compared against a plain-arithmetic model
//               of the dot product.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qdot_engine;

  localparam int N     = 32;
  localparam int Q     = 15;
  localparam int LANES = 4;
  localparam int LEN_W = 16;
`ifdef QDOT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [LEN_W-1:0]   len;
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic [LANES*N-1:0] in_a;
  logic [LANES*N-1:0] in_b;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       out_c;
  logic               ovfl;
  logic               busy;

  int checks = 0;
  int errors = 0;

  logic [LANES*N-1:0] tb_a [$];
  logic [LANES*N-1:0] tb_b [$];

  qdot_engine #(
    .N     (N),
    .Q     (Q),
    .LANES (LANES),
    .LEN_W (LEN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .ovfl      (ovfl),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- model
  function automatic longint model_acc(input int n);
    longint s = 0;
    for (int i = 0; i < n; i++) begin
      logic [LANES*N-1:0] va;
      logic [LANES*N-1:0] vb;
      va = tb_a[i];
      vb = tb_b[i];
      for (int k = 0; k < LANES; k++) begin
        logic [N-1:0] aw;
        logic [N-1:0] bw;
        longint pa;
        longint pb;
        aw = va[k*N +: N];
        bw = vb[k*N +: N];
        pa = longint'($signed(aw));
        pb = longint'($signed(bw));
        s  = s + ((pa * pb) >>> Q);
      end
    end
    return s;
  endfunction

  function automatic bit model_ovfl(input longint s);
    longint hi;
    hi = (64'sd1 <<< (N - 1)) - 1;
    return (s > hi) || (s < -hi - 1);
  endfunction

  function automatic logic [N-1:0] model_out(input longint s);
    longint hi;
    longint t;
    hi = (64'sd1 <<< (N - 1)) - 1;
    t  = s;
    if (SAT && s > hi) t = hi;
    if (SAT && s < -hi - 1) t = -hi - 1;
    return t[N-1:0];
  endfunction

  // ---------------------------------------------------------------- stimulus
  task automatic fill_uniform(input int n, input logic [N-1:0] a,
                              input logic [N-1:0] b);
    tb_a.delete();
    tb_b.delete();
    for (int i = 0; i < n; i++) begin
      tb_a.push_back({LANES{a}});
      tb_b.push_back({LANES{b}});
    end
  endtask

  function automatic logic [N-1:0] rand_word();
    logic [N-1:0] w;
    case ($urandom_range(2))
      0:       w = $urandom();
      1:       w = N'($urandom_range(1 << 18));
      default: w = -N'($urandom_range(1 << 18));
    endcase
    return w;
  endfunction

  task automatic fill_random(input int n);
    tb_a.delete();
    tb_b.delete();
    for (int i = 0; i < n; i++) begin
      logic [LANES*N-1:0] va;
      logic [LANES*N-1:0] vb;
      for (int k = 0; k < LANES; k++) begin
        va[k*N +: N] = rand_word();
        vb[k*N +: N] = rand_word();
      end
      tb_a.push_back(va);
      tb_b.push_back(vb);
    end
  endtask

  // Runs one job from the queues; returns what the consumer observed.
  // lat counts cycles from the trigger cycle (last accept, or start for
  // len 0) to the first cycle with out_valid high.
  task automatic run_job(input int n, input int gap, input int rnd_pct,
                         input int hold, output logic [N-1:0] c,
                         output logic ov, output int lat, output bit tmo);
    int idx;
    int budget;
    bit acc_ok;
    tmo = 1'b0;
    c   = '0;
    ov  = 1'b0;
    len = LEN_W'(n);
    start = 1'b1;
    tick();
    start  = 1'b0;
    idx    = 0;
    budget = 0;
    while (idx < n && budget < 2000) begin
      in_a     = tb_a[idx];
      in_b     = tb_b[idx];
      in_valid = ($urandom_range(99) >= rnd_pct);
      acc_ok   = in_valid && in_ready;
      tick();
      budget++;
      if (acc_ok) begin
        idx++;
        in_valid = 1'b0;
        if (idx < n) repeat (gap) tick();
      end
    end
    in_valid = 1'b0;
    if (idx < n) tmo = 1'b1;
    lat = 1;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!out_valid) tmo = 1'b1;
    repeat (hold) tick();
    c  = out_c;
    ov = ovfl;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_c !== '0) begin errors++; $display("FAIL reset_out_c: got %h expected 0", out_c); end
    checks++; if (ovfl !== 1'b0) begin errors++; $display("FAIL reset_ovfl: got %b expected 0", ovfl); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got busy=%b in_ready=%b expected 0 0", busy, in_ready); end
  endtask

  task automatic test_basic();
    logic [N-1:0] c; logic ov; int lat; bit tmo;
    fill_uniform(3, 32'h0000_8000, 32'h0000_4000);
    run_job(3, 0, 0, 0, c, ov, lat, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL basic_timeout: got timeout expected result"); end
    checks++; if (c !== 32'h0003_0000) begin errors++; $display("FAIL basic_out_c: got %h expected 00030000", c); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL basic_ovfl: got %b expected 0", ov); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_signed_bubble();
    logic [N-1:0] c; logic ov; int lat; bit tmo;
    logic [LANES*N-1:0] va;
    logic [LANES*N-1:0] vb;
    va = {32'h0000_8000, 32'h0000_0000, 32'h0001_0000, 32'hFFFF_4000};
    vb = {32'h0000_8000, 32'h0003_8000, 32'hFFFF_E000, 32'h0001_0000};
    tb_a.delete(); tb_b.delete();
    repeat (2) begin tb_a.push_back(va); tb_b.push_back(vb); end
    run_job(2, 1, 0, 0, c, ov, lat, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL signed_timeout: got timeout expected result"); end
    checks++; if (c !== 32'hFFFD_8000) begin errors++; $display("FAIL signed_out_c: got %h expected fffd8000", c); end
    checks++; if (ov !== 1'b0 || lat !== 2) begin errors++; $display("FAIL signed_ovfl_lat: got ovfl=%b lat=%0d expected 0 2", ov, lat); end
  endtask

  task automatic test_overflow();
    logic [N-1:0] c; logic ov; int lat; bit tmo;
    logic [LANES*N-1:0] va;
    logic [LANES*N-1:0] vb;
    longint s;
    // +2^31: one past the positive limit.
    va = '0; vb = '0;
    va[N-1:0] = 32'h0080_0000; vb[N-1:0] = 32'h0080_0000;
    tb_a.delete(); tb_b.delete(); tb_a.push_back(va); tb_b.push_back(vb);
    s = model_acc(1);
    run_job(1, 0, 0, 2, c, ov, lat, tmo);
    checks++; if (tmo || ov !== 1'b1) begin errors++; $display("FAIL ovfl_pos_flag: got %b tmo=%0d expected 1", ov, tmo); end
    checks++; if (c !== (SAT ? 32'h7FFF_FFFF : 32'h8000_0000) || c !== model_out(s)) begin errors++; $display("FAIL ovfl_pos_out_c: got %h expected %h", c, model_out(s)); end
    // -2^31: exactly the negative limit, still fits.
    va[N-1:0] = 32'hFF80_0000;
    tb_a.delete(); tb_a.push_back(va);
    run_job(1, 0, 0, 0, c, ov, lat, tmo);
    checks++; if (tmo || ov !== 1'b0 || c !== 32'h8000_0000) begin errors++; $display("FAIL ovfl_neg_edge: got ovfl=%b c=%h expected 0 80000000", ov, c); end
    // -2^31-1: one past the negative limit.
    va[2*N-1:N] = 32'hFFFF_FFFF; vb[2*N-1:N] = 32'h0000_8000;
    tb_a.delete(); tb_b.delete(); tb_a.push_back(va); tb_b.push_back(vb);
    s = model_acc(1);
    run_job(1, 0, 0, 0, c, ov, lat, tmo);
    checks++; if (tmo || ov !== 1'b1 || c !== model_out(s)) begin errors++; $display("FAIL ovfl_neg: got ovfl=%b c=%h expected 1 %h", ov, c, model_out(s)); end
  endtask

  task automatic test_empty_backpressure();
    int bad = 0;
    len = '0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_c !== '0 || ovfl !== 1'b0) begin errors++; $display("FAIL empty_first: got v=%b c=%h o=%b expected 1 0 0", out_valid, out_c, ovfl); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin start = 1'b1; len = LEN_W'(7); end
      tick();
      start = 1'b0;
      if (out_valid !== 1'b1 || out_c !== '0 || busy !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL empty_hold: got %0d unstable cycles expected 0", bad); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL empty_release: got v=%b busy=%b expected 0 0", out_valid, busy); end
  endtask

  task automatic feed_two_beats();
    fill_uniform(2, 32'h0000_8000, 32'h0000_8000);
    len = LEN_W'(5); start = 1'b1;
    tick();
    start = 1'b0;
    in_a = tb_a[0]; in_b = tb_b[0]; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
  endtask

  task automatic test_abort_reset();
    logic [N-1:0] c; logic ov; int lat; bit tmo;
    int seen = 0;
    feed_two_beats();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL clear_idle: got busy=%b v=%b rdy=%b expected 0 0 0", busy, out_valid, in_ready); end
    repeat (4) begin tick(); if (out_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL clear_no_result: got %0d valid cycles expected 0", seen); end
    feed_two_beats();
    rst_n = 1'b0;
    #1;
    checks++; if ({in_ready, out_valid, ovfl, busy} !== 4'b0 || out_c !== '0) begin errors++; $display("FAIL async_reset: got rdy=%b v=%b o=%b busy=%b c=%h expected all 0", in_ready, out_valid, ovfl, busy, out_c); end
    tick();
    rst_n = 1'b1;
    tick();
    fill_uniform(1, 32'h0000_8000, 32'h0000_8000);
    run_job(1, 0, 0, 0, c, ov, lat, tmo);
    checks++; if (tmo || c !== 32'h0002_0000 || ov !== 1'b0) begin errors++; $display("FAIL after_abort_job: got c=%h o=%b tmo=%0d expected 00020000 0 0", c, ov, tmo); end
  endtask

  task automatic test_simultaneous();
    len = LEN_W'(3); start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_clear_idle: got busy=%b expected 0", busy); end
    len = '0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL done_reached: got %b expected 1", out_valid); end
    clear = 1'b1; out_ready = 1'b1;
    tick();
    clear = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clear_in_done: got v=%b busy=%b expected 0 0", out_valid, busy); end
  endtask

  task automatic test_random_jobs();
    logic [N-1:0] c; logic ov; int lat; bit tmo; int n; longint s;
    for (int j = 0; j < 12; j++) begin
      n = $urandom_range(1, 6);
      fill_random(n);
      s = model_acc(n);
      run_job(n, $urandom_range(1), 30, $urandom_range(3), c, ov, lat, tmo);
      checks++; if (tmo || c !== model_out(s)) begin errors++; $display("FAIL rand_out_c[%0d]: got %h expected %h tmo=%0d", j, c, model_out(s), tmo); end
      checks++; if (ov !== model_ovfl(s)) begin errors++; $display("FAIL rand_ovfl[%0d]: got %b expected %b", j, ov, model_ovfl(s)); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected 2", j, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] c; logic ov; int lat; bit tmo; longint s;
    for (int j = 0; j < 3; j++) begin
      fill_random(j + 2);
      s = model_acc(j + 2);
      run_job(j + 2, 0, 0, 0, c, ov, lat, tmo);
      checks++; if (tmo || c !== model_out(s) || ov !== model_ovfl(s) || lat !== 2) begin errors++; $display("FAIL b2b[%0d]: got c=%h o=%b lat=%0d expected %h %b 2", j, c, ov, lat, model_out(s), model_ovfl(s)); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; clear = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_signed_bubble();
    test_overflow();
    test_empty_backpressure();
    test_abort_reset();
    test_simultaneous();
    test_random_jobs();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qdot_engine.md
Name: qdot_engine

Overview:
- Parametrised successor to the single-lane Q-format MAC: a streaming multi-lane fixed-point dot-product engine.
- Each accepted beat carries LANES operand pairs. Beat count per job is programmable at start.
- Products are pipelined into a full-precision accumulator. The result is returned over a valid/ready output handshake.
- Sits between the operand buffers and the layer-output writer in the accelerator datapath.

Parameters:
- N, 32, operand/result width, signed two's complement, Q fractional bits
- Q, 15, fractional bits
- LANES, 4, multiply lanes per beat (>=1)
- LEN_W, 16, width of beat-count field; max job length 2^LEN_W-1 beats

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job request; sampled only in IDLE
- len  in  LEN_W  beats in job; latched when start is accepted
- clear  in  1  synchronous abort; returns to IDLE
- in_valid  in  1  operand beat valid
- in_ready  out  1  engine accepts beat
- in_a  in  LANES*N  lane k at bits [k*N +: N]
- in_b  in  LANES*N  lane k at bits [k*N +: N]
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts result
- out_c  out  N  Q-format result
- ovfl  out  1  accumulator does not fit N-bit signed; valid with out_valid
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: in_ready=0, out_valid=0, out_c=0, ovfl=0, busy=0.
  - Internal: state=IDLE, accumulator=0, beat counter=0, pipeline valid=0.
- Arithmetic:
  - Lane product p_k = (a_k*b_k) >>> Q. Arithmetic shift, truncation toward -inf, width 2N-Q.
  - Lane sum is 2N-Q+$clog2(LANES) bits, sign-extended.
  - Accumulator ACC_W = 2N-Q+$clog2(LANES)+LEN_W bits, signed; never overflows internally.
- Pipeline:
  - On an accepted beat (in_valid && in_ready), the lane sum is registered into stage1 with s1_valid=1.
  - On the next edge, the accumulator adds stage1 when s1_valid.
- Result: out_c is the accumulator reduced to N bits (see Optional Feature). ovfl=1 iff the accumulator is outside [-2^(N-1), 2^(N-1)-1].
- State machine: IDLE, RUN, DRAIN, DONE.
  - IDLE: in_ready=0.
    - start && !clear: latch len, zero the accumulator and counter.
    - len==0 goes to DONE with result 0.
    - Otherwise goes to RUN.
  - RUN: in_ready=1 while count<len. Each accepted beat increments count. The edge accepting beat number len goes to DRAIN. Bubbles (in_valid=0) stall without penalty.
  - DRAIN: in_ready=0. Final stage1 is added. Goes to DONE.
  - DONE: out_valid=1. out_c and ovfl are stable until out_valid && out_ready, then go to IDLE. out_valid drops the following cycle.
- Latency:
  - out_valid rises 2 cycles after the cycle in which the last beat is accepted.
  - For len==0, out_valid rises 1 cycle after start.
- start while busy is ignored; len is not relatched.
- clear has priority over everything, including start in IDLE and out_ready in DONE.
  - Next state is IDLE; accumulator, counter and s1_valid are zeroed.
  - out_valid=0 from the next cycle; no result is produced.
- A new start is accepted the cycle after the DONE handshake, i.e. the first cycle back in IDLE.

Optional Feature:
- Macro: QDOT_SAT_EN.
- Defined: out_c clamps to 2^(N-1)-1 when positive-overflowing and to -2^(N-1) when negative-overflowing.
- Undefined: out_c = accumulator[N-1:0], two's-complement wrap.
- ovfl behaves identically in both builds.

Decomposition:
- Package qdot_pkg holds:
  - state_t enum {IDLE, RUN, DRAIN, DONE};
  - localparam functions for the product, lane-sum and ACC_W widths;
  - function sat_to_n(acc) for the clamp.
- Sub-module qdot_lane_mul, instantiated LANES times: combinational signed N x N multiply followed by >>> Q, output 2N-Q bits.
- FSM, counter, stage1 and accumulator live in qdot_engine.

Test Plan:
- Basic job: LANES=4, len=3, all a=0x00008000 (1.0), b=0x00004000 (0.5), in_valid constant -> out_c=0x00030000 (6.0), ovfl=0, out_valid 2 cycles after third accept.
- Signed lanes and a bubble: len=2; lanes a={-1.5,2.0,0,1.0}, b={2.0,-0.25,7.0,1.0}; in_valid low one cycle between beats -> out_c = 2*(-3.0-0.5+0+1.0) = -5.0 = 0xFFFD8000.
- Overflow: LANES=1, len=1, a=b=0x00800000 (256.0) -> ovfl=1; out_c=0x7FFFFFFF with QDOT_SAT_EN, 0x80000000 without.
- Empty job and output backpressure: len=0, out_ready=0 for 5 cycles -> out_valid=1 from start+1, out_c=0 stable; start pulsed during DONE is ignored; handshake then IDLE.
- Abort and reset: len=5, assert clear after 2 beats -> IDLE next cycle, busy=0, no out_valid; repeat with rst_n pulsed mid-RUN -> all outputs 0 immediately. A following len=1 job of 1.0*1.0*LANES=4 gives 0x00020000.
- Simultaneous events: start && clear in IDLE -> stays IDLE; clear && out_ready in DONE -> IDLE, single out_valid cycle seen by the consumer.
